// File: rtl/decoder_scan.sv
// Registered N-to-2**N one-hot decoder with an auto-stepping scan mode for digit/row select.
// Optional `wrap` output (pulse on LAST -> 0 scan step) enabled by defining DECODER_SCAN_WRAP_EN.
module decoder_scan #(
   parameter int N        = 2,
   parameter int SCAN_DIV = 4,
   parameter int LAST     = 2**N-1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            mode,
   input  logic [N-1:0]    x,
   input  logic            x_valid,
   output logic [2**N-1:0] y,
   output logic [N-1:0]    idx,
   output logic            y_valid
`ifdef DECODER_SCAN_WRAP_EN
   ,output logic           wrap
`endif
);
   localparam int W  = 2**N;
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [W-1:0]  ONE      = W'(1);
   localparam logic [N-1:0]  LAST_I   = N'(LAST);
   localparam logic [DW-1:0] DIV_TC   = DW'(SCAN_DIV-1);
   // Bit i set when index i lies inside the scan range 0..LAST.
   localparam logic [W-1:0]  IN_RANGE = (ONE << (LAST+1)) - ONE;

   typedef enum logic [1:0] {S_IDLE, S_DEC, S_SCAN} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div, div_nxt;
   logic [W-1:0]  y_nxt;
   logic [N-1:0]  idx_nxt;
   logic          y_valid_nxt;
   logic          at_last;
   logic [N-1:0]  step_idx;
`ifdef DECODER_SCAN_WRAP_EN
   logic          wrap_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         div     <= '0;
         y       <= '0;
         idx     <= '0;
         y_valid <= 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
         wrap    <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         y       <= y_nxt;
         idx     <= idx_nxt;
         y_valid <= y_valid_nxt;
`ifdef DECODER_SCAN_WRAP_EN
         wrap    <= wrap_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      div_nxt     = div;
      y_nxt       = y;
      idx_nxt     = idx;
      y_valid_nxt = 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
      wrap_nxt    = 1'b0;
`endif
      at_last  = (idx == LAST_I);
      step_idx = at_last ? '0 : idx + 1'b1;
      if (en) begin
         case (state)
            S_SCAN: begin
               if (mode) begin
                  if (div == DIV_TC) begin
                     div_nxt     = '0;
                     idx_nxt     = step_idx;
                     y_nxt       = ONE << step_idx;
                     y_valid_nxt = 1'b1;
`ifdef DECODER_SCAN_WRAP_EN
                     wrap_nxt    = at_last;
`endif
                  end else begin
                     div_nxt = div + 1'b1;
                  end
               end else begin
                  // Leaving scan: y keeps the last scanned digit unless x arrives now.
                  state_nxt = S_DEC;
                  div_nxt   = '0;
                  if (x_valid) begin
                     idx_nxt     = x;
                     y_nxt       = ONE << x;
                     y_valid_nxt = 1'b1;
                  end
               end
            end
            default: begin
               if (mode) begin
                  state_nxt   = S_SCAN;
                  div_nxt     = '0;
                  y_valid_nxt = 1'b1;
                  if ((IN_RANGE & (ONE << idx)) == '0) begin
                     idx_nxt = '0;
                     y_nxt   = ONE;
                  end else begin
                     y_nxt   = ONE << idx;
                  end
               end else if (x_valid) begin
                  state_nxt   = S_DEC;
                  idx_nxt     = x;
                  y_nxt       = ONE << x;
                  y_valid_nxt = 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_decoder_scan.sv
// Randomised bench for decoder_scan: three parameterisations share one stimulus stream and
// are checked each cycle against an index/tick reference model, plus literal directed checks.
module tb_decoder_scan;
   logic       clk, rst, en, mode, x_valid;
   logic [1:0] x;
   logic [3:0] y_o   [3];
   logic [1:0] idx_o [3];
   logic       yv_o  [3];
`ifdef DECODER_SCAN_WRAP_EN
   logic       wr_o  [3];
`endif

   localparam int DIVS  [3] = '{2, 1, 2};
   localparam int LASTS [3] = '{3, 2, 1};

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_idx [3];
   int m_tick [3];
   bit m_started [3];
   bit m_scan [3];
   bit m_yv [3];
   bit m_wr [3];

   decoder_scan #(.N(2), .SCAN_DIV(2), .LAST(3)) u0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .x_valid(x_valid),
      .y(y_o[0]), .idx(idx_o[0]), .y_valid(yv_o[0])
`ifdef DECODER_SCAN_WRAP_EN
      , .wrap(wr_o[0])
`endif
   );
   decoder_scan #(.N(2), .SCAN_DIV(1), .LAST(2)) u1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .x_valid(x_valid),
      .y(y_o[1]), .idx(idx_o[1]), .y_valid(yv_o[1])
`ifdef DECODER_SCAN_WRAP_EN
      , .wrap(wr_o[1])
`endif
   );
   decoder_scan #(.N(2), .SCAN_DIV(2), .LAST(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .x_valid(x_valid),
      .y(y_o[2]), .idx(idx_o[2]), .y_valid(yv_o[2])
`ifdef DECODER_SCAN_WRAP_EN
      , .wrap(wr_o[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_idx[i] = 0; m_tick[i] = 0; m_started[i] = 0;
         m_scan[i] = 0; m_yv[i] = 0; m_wr[i] = 0;
      end
   endtask

   // One enabled clock edge as the behaviour is described: indices and tick counts.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         m_yv[i] = 0;
         m_wr[i] = 0;
         if (en) begin
            if (mode) begin
               if (!m_scan[i]) begin
                  m_scan[i] = 1; m_started[i] = 1; m_tick[i] = 0; m_yv[i] = 1;
                  if (m_idx[i] > LASTS[i]) m_idx[i] = 0;
               end else begin
                  m_tick[i]++;
                  if (m_tick[i] == DIVS[i]) begin
                     m_tick[i] = 0;
                     m_wr[i]   = (m_idx[i] == LASTS[i]);
                     m_idx[i]  = m_wr[i] ? 0 : m_idx[i] + 1;
                     m_yv[i]   = 1;
                  end
               end
            end else begin
               m_scan[i] = 0;
               m_tick[i] = 0;
               if (x_valid) begin
                  m_idx[i] = int'(x); m_started[i] = 1; m_yv[i] = 1;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.y", i), int'(y_o[i]), m_started[i] ? (1 << m_idx[i]) : 0);
         chk($sformatf("u%0d.idx", i), int'(idx_o[i]), m_idx[i]);
         chk($sformatf("u%0d.y_valid", i), int'(yv_o[i]), int'(m_yv[i]));
`ifdef DECODER_SCAN_WRAP_EN
         chk($sformatf("u%0d.wrap", i), int'(wr_o[i]), int'(m_wr[i]));
`endif
      end
   end

   task automatic cyc(input bit e, input bit m, input int xx, input bit v);
      en = e; mode = m; x = xx[1:0]; x_valid = v;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Reset asserted between edges must clear outputs without waiting for a clock.
   task automatic mid_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst.u%0d.y", i), int'(y_o[i]), 0);
         chk($sformatf("rst.u%0d.idx", i), int'(idx_o[i]), 0);
         chk($sformatf("rst.u%0d.y_valid", i), int'(yv_o[i]), 0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int seq0 [9] = '{1, 1, 2, 2, 4, 4, 8, 8, 1};
      int seq1 [9] = '{1, 2, 4, 1, 2, 4, 1, 2, 4};
      bit m;
      rst = 1'b1; en = 1'b0; mode = 1'b0; x = '0; x_valid = 1'b0;
      model_reset();
      #1;
      chk("reset.y", int'(y_o[0]), 0);
      chk("reset.y_valid", int'(yv_o[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // decode 0..3 on consecutive edges, then hold
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, k, 1);
         chk("dec.y", int'(y_o[0]), 1 << k);
         chk("dec.y_valid", int'(yv_o[0]), 1);
      end
      cyc(1, 0, 0, 0);
      chk("dec.hold.y", int'(y_o[0]), 8);
      chk("dec.hold.y_valid", int'(yv_o[0]), 0);

      // scan from reset: u0 steps every 2 clocks, u1 (LAST=2) every clock
      mid_reset();
      for (int k = 0; k < 9; k++) begin
         cyc(1, 1, 0, 0);
         chk("scan.u0.y", int'(y_o[0]), seq0[k]);
         chk("scan.u1.y", int'(y_o[1]), seq1[k]);
      end
      cyc(1, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 0, 0);
         chk("freeze.y", int'(y_o[0]), 1);
         chk("freeze.y_valid", int'(yv_o[0]), 0);
      end
      cyc(1, 1, 0, 0);
      chk("resume.y", int'(y_o[0]), 2);
      chk("resume.y_valid", int'(yv_o[0]), 1);

      // x_valid ignored in scan; decode on the switch; forced index on re-entry
      cyc(1, 1, 3, 1);
      chk("scan.xign.y", int'(y_o[0]), 2);
      cyc(1, 0, 2, 1);
      chk("switch.y", int'(y_o[0]), 4);
      chk("switch.idx", int'(idx_o[0]), 2);
      cyc(1, 1, 0, 0);
      chk("reentry.u2.y", int'(y_o[2]), 1);
      chk("reentry.u2.idx", int'(idx_o[2]), 0);
      chk("reentry.u0.y", int'(y_o[0]), 4);

      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      mid_reset();

      // random traffic
      m = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(15) == 0) m = ~m;
         cyc($urandom_range(9) != 0, m, int'($urandom_range(3)), $urandom_range(1) == 1);
         if ($urandom_range(299) == 0) mid_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
